// File: rtl/arb_requester.sv
// arb_requester: request/grant agent for one shared-resource arbiter port (optional checker: ARB_REQ_PROTO_CHK_EN)
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic             done,
  output logic             timeout,
  output logic             busy,
  output logic             proto_err
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [7:0]       wait_cnt;
  logic [7:0]       gap_cnt;
  logic             abort;
  assign job_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign beat      = (state == REQ || state == XFER) && gnt;
  assign done      = beat && rem == '0;
  assign timeout   = state == REQ && !gnt && wait_cnt >= 8'(TIMEOUT);
`ifdef ARB_REQ_PROTO_CHK_EN
  // Grant lost mid-burst ends the job early; the loss or a stray grant while idle is latched as an error
  assign abort = state == XFER && !gnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) proto_err <= 1'b0;
    else if (abort || (state == IDLE && gnt)) proto_err <= 1'b1;
`else
  assign abort     = 1'b0;
  assign proto_err = 1'b0;
`endif
  // Request/transfer/release sequencing; req is driven straight from this register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state    <= IDLE;
      req      <= 1'b0;
      rem      <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (job_valid) begin
          rem      <= job_len;
          wait_cnt <= '0;
          req      <= 1'b1;
          state    <= REQ;
        end
        REQ, XFER: if (done || timeout || abort) begin
          req     <= 1'b0;
          gap_cnt <= '0;
          state   <= REL;
        end else if (beat) begin
          rem   <= rem - 1'b1;
          state <= XFER;
        end else if (state == REQ && wait_cnt != 8'hff) wait_cnt <= wait_cnt + 8'd1;
        REL: if (gap_cnt == 8'(GAP - 1)) state <= IDLE;
             else gap_cnt <= gap_cnt + 8'd1;
      endcase
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed and random checks of arb_requester against a job-level reference model
module tb_arb_requester;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int GAP     = 2;
`ifdef ARB_REQ_PROTO_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, job_valid = 1'b0, gnt = 1'b0;
  logic [LEN_W-1:0] job_len = '0;
  logic job_ready, req, beat, done, timeout, busy, proto_err;
  int checks = 0, errors = 0;
  int beat_cnt, done_cnt, to_cnt;
  bit m_job, m_got, m_perr, last_req;
  int m_left, m_wait, m_gap;

  always #5 clk = ~clk;

  arb_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .resetn(resetn), .job_valid(job_valid), .job_len(job_len),
    .job_ready(job_ready), .req(req), .gnt(gnt), .beat(beat), .done(done),
    .timeout(timeout), .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic a, input logic e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, a, e);
    end
  endtask

  task automatic chki(input string tag, input int a, input int e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, a, e);
    end
  endtask

  task automatic model_reset();
    m_job = 0; m_got = 0; m_perr = 0; last_req = 0;
    m_left = 0; m_wait = 0; m_gap = 0;
  endtask

  task automatic clear_counts();
    beat_cnt = 0; done_cnt = 0; to_cnt = 0;
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the job model at posedge
  task automatic cyc(input bit jv, input int len, input bit g);
    bit e_ready, e_beat, e_done, e_to;
    job_valid = jv; job_len = LEN_W'(len); gnt = g;
    #1;
    e_ready = !m_job && m_gap == 0;
    e_beat  = m_job && g;
    e_done  = e_beat && m_left == 1;
    e_to    = m_job && !m_got && !g && m_wait >= TIMEOUT;
    chk("job_ready", job_ready, e_ready);
    chk("req", req, m_job);
    chk("beat", beat, e_beat);
    chk("done", done, e_done);
    chk("timeout", timeout, e_to);
    chk("busy", busy, m_job || m_gap > 0);
    chk("proto_err", proto_err, m_perr);
    beat_cnt += int'(beat); done_cnt += int'(done); to_cnt += int'(timeout);
    last_req = m_job;
    @(posedge clk);
    if (e_ready) begin
      if (PCHK && g) m_perr = 1;
      if (jv) begin m_job = 1; m_left = len + 1; m_wait = 0; m_got = 0; end
    end else if (m_job) begin
      if (g) begin
        m_left--; m_got = 1;
        if (m_left == 0) begin m_job = 0; m_gap = GAP; end
      end else if (e_to || (PCHK && m_got)) begin
        if (m_got) m_perr = 1;
        m_job = 0; m_gap = GAP;
      end else if (!m_got) m_wait++;
    end else m_gap--;
    @(negedge clk);
  endtask

  // Arbiter-like grant: registered copy of req, optionally withheld
  task automatic arb(input bit jv, input int len, input bit allow);
    cyc(jv, len, last_req && allow);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit deny;
    model_reset();
    clear_counts();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    // reset state and a quiet cycle
    arb(0, 0, 1);
    // 4-beat burst with a free arbiter
    clear_counts();
    arb(1, 3, 1);
    repeat (11) arb(0, 0, 1);
    chki("t1_beats", beat_cnt, 4);
    chki("t1_dones", done_cnt, 1);
    // no grant ever: abandon after TIMEOUT
    clear_counts();
    arb(1, 5, 0);
    repeat (22) arb(0, 0, 0);
    chki("t2_timeouts", to_cnt, 1);
    chki("t2_beats", beat_cnt, 0);
    chki("t2_dones", done_cnt, 0);
    // single-beat job; trailing grant in release must not beat
    clear_counts();
    arb(1, 0, 1);
    repeat (8) arb(0, 0, 1);
    chki("t3_beats", beat_cnt, 1);
    chki("t3_dones", done_cnt, 1);
    // job_valid held high: one accept per idle visit
    clear_counts();
    repeat (30) arb(1, 2, 1);
    chki("t4_dones", done_cnt, 4);
    repeat (10) arb(0, 0, 1);
    // asynchronous reset mid-burst
    arb(1, 7, 1);
    repeat (3) arb(0, 0, 1);
    clear_counts();
    resetn = 1'b0;
    #1;
    chk("rst_req", req, 1'b0);
    chk("rst_beat", beat, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", job_ready, 1'b1);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) arb(0, 0, 1);
    chki("t5_dones", done_cnt, 0);
    // grant drops after 2 of 4 beats
    clear_counts();
    cyc(1, 3, 0);
    cyc(0, 0, 0);
    repeat (2) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    repeat (2) cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);
    chki("t6_beats", beat_cnt, PCHK ? 2 : 4);
    chki("t6_dones", done_cnt, PCHK ? 0 : 1);
    // grant arrives in the timeout cycle: grant wins
    model_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    clear_counts();
    cyc(1, 1, 0);
    repeat (15) cyc(0, 0, 0);
    repeat (2) cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);
    chki("t7_timeouts", to_cnt, 0);
    chki("t7_beats", beat_cnt, 2);
    chki("t7_dones", done_cnt, 1);
    // randomized traffic with occasional long denial phases
    deny = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) deny = ($urandom % 3) == 0;
      arb(($urandom % 3) == 0, int'($urandom % 16), !deny && ($urandom % 4) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
